// File: rtl/vga_fb_fetch_arb.sv
// Owner of the single-port pixel framebuffer RAM: streams one framebuffer row into the
// display line buffer while granting a pixel writer a guaranteed slot every WR_EVERY cycles.
module vga_fb_fetch_arb #(
    parameter int FB_W     = 160,
    parameter int FB_H     = 120,
    parameter int PIX_W    = 12,
    parameter int ADDR_W   = 15,
    parameter int WR_EVERY = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              fetch_req,
    input  logic [6:0]        fetch_row,
    output logic              fetch_busy,
    output logic              fetch_done,
    output logic              err,
    output logic              lb_we,
    output logic [7:0]        lb_waddr,
    output logic [PIX_W-1:0]  lb_wdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [PIX_W-1:0]  ram_wdata,
    input  logic [PIX_W-1:0]  ram_rdata,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data
);
    localparam int                SLOT_W    = (WR_EVERY > 2) ? $clog2(WR_EVERY) : 1;
    localparam logic [7:0]        COL_LAST  = 8'(FB_W - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(WR_EVERY - 1);
    localparam logic [7:0]        ROW_LIMIT = 8'(FB_H);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state;
    logic [7:0]        col;
    logic [SLOT_W-1:0] slot;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] row_base;
    logic              row_ok;
    logic              slot_cyc;
    logic              wr_fire;
    logic              rd_vld_p0;
    logic              last_rd;
    logic              vld_p1;
    logic [7:0]        col_p1;

    assign row_ok   = ({1'b0, fetch_row} < ROW_LIMIT);
    assign row_base = ADDR_W'(32'(fetch_row) * 32'(FB_W));

    // The writer slot is offered whether or not the writer wants it; an unused slot
    // simply becomes another read.
    assign slot_cyc  = (state == FETCH) && (slot == SLOT_LAST);
    assign wr_ready  = nrst && ((state == IDLE) || (state == DRAIN) || slot_cyc);
    assign wr_fire   = wr_ready && wr_valid;
    assign rd_vld_p0 = (state == FETCH) && !wr_fire;
    assign last_rd   = rd_vld_p0 && (col == COL_LAST);

    assign ram_en    = wr_fire || rd_vld_p0;
    assign ram_we    = wr_fire;
    assign ram_addr  = wr_fire ? wr_addr : base + ADDR_W'(col);
    assign ram_wdata = wr_data;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            col        <= '0;
            slot       <= '0;
            fetch_busy <= 1'b0;
            fetch_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            fetch_done <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (fetch_req) begin
                        if (row_ok) begin
                            state      <= FETCH;
                            col        <= '0;
                            slot       <= '0;
                            fetch_busy <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    err  <= fetch_req;
                    slot <= slot_cyc ? '0 : slot + SLOT_W'(1);
                    if (rd_vld_p0) begin
                        col <= last_rd ? '0 : col + 8'd1;
                    end
                    if (last_rd) begin
                        state      <= DRAIN;
                        fetch_done <= 1'b1;
                    end
                end
                DRAIN: begin
                    err        <= fetch_req;
                    state      <= IDLE;
                    fetch_busy <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    fetch_busy <= 1'b0;
                end
            endcase
        end
    end

    // p0 -> p1: RAM read issued; data returns next cycle alongside its column
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= rd_vld_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_vld_p0) begin
            col_p1 <= col;
        end
        if ((state == IDLE) && fetch_req && row_ok) begin
            base <= row_base;
        end
    end

    assign lb_we    = vld_p1;
    assign lb_waddr = col_p1;
    assign lb_wdata = ram_rdata;

endmodule

// File: tb/tb_vga_fb_fetch_arb.sv
// Scoreboard bench for vga_fb_fetch_arb: stimulus predicts reads, line-buffer writes,
// writer grants, fetch_done and err; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_vga_fb_fetch_arb;
    localparam int FB_W     = 160;
    localparam int FB_H     = 120;
    localparam int PIX_W    = 12;
    localparam int ADDR_W   = 15;
    localparam int WR_EVERY = 8;
    localparam int MEM_N    = 1 << ADDR_W;

    typedef struct packed {
        logic [7:0]       col;
        logic [PIX_W-1:0] data;
    } lb_t;

    logic              clk = 1'b0;
    logic              nrst;
    logic              fetch_req;
    logic [6:0]        fetch_row;
    logic              fetch_busy;
    logic              fetch_done;
    logic              err;
    logic              lb_we;
    logic [7:0]        lb_waddr;
    logic [PIX_W-1:0]  lb_wdata;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [PIX_W-1:0]  ram_wdata;
    logic [PIX_W-1:0]  ram_rdata;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;

    vga_fb_fetch_arb #(
        .FB_W(FB_W), .FB_H(FB_H), .PIX_W(PIX_W), .ADDR_W(ADDR_W), .WR_EVERY(WR_EVERY)
    ) dut (
        .clk(clk), .nrst(nrst),
        .fetch_req(fetch_req), .fetch_row(fetch_row),
        .fetch_busy(fetch_busy), .fetch_done(fetch_done), .err(err),
        .lb_we(lb_we), .lb_waddr(lb_waddr), .lb_wdata(lb_wdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Framebuffer RAM (environment) and the bench's reference image of its contents
    logic [PIX_W-1:0] mem     [MEM_N];
    logic [PIX_W-1:0] ref_mem [MEM_N];
    bit               mem_loaded = 1'b0;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int a = 0; a < MEM_N; a++) mem[a] <= ref_mem[a];
            mem_loaded <= 1'b1;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    int   errors = 0;
    int   checks = 0;
    int   exp_rd[$];
    lb_t  exp_lb[$];
    int   exp_gnt[$];
    int   exp_done[$];
    int   exp_err[$];
    int   bz_start = 1;
    int   bz_end   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queued predictions
    always @(negedge clk) begin
        bit  g, e;
        lb_t el;
        if (nrst) begin
            chk("fetch_busy", 32'(fetch_busy), 32'(cyc >= bz_start && cyc <= bz_end));

            g = wr_valid && wr_ready;
            e = (exp_gnt.size() > 0) && (exp_gnt[0] == cyc);
            if (e) void'(exp_gnt.pop_front());
            if (g || e) chk("wr_grant", 32'(g), 32'(e));
            if (g) begin
                chk("wr_ram_we", 32'(ram_en && ram_we), 32'(1));
                chk("wr_ram_addr", 32'(ram_addr), 32'(wr_addr));
                chk("wr_ram_wdata", 32'(ram_wdata), 32'(wr_data));
            end

            if (ram_en && !ram_we) begin
                if (exp_rd.size() == 0) chk("rd_unexpected", 32'(ram_addr), 32'hFFFF_FFFF);
                else chk("rd_addr", 32'(ram_addr), 32'(exp_rd.pop_front()));
            end

            if (lb_we) begin
                if (exp_lb.size() == 0) begin
                    chk("lb_unexpected", 32'(lb_waddr), 32'hFFFF_FFFF);
                end else begin
                    el = exp_lb.pop_front();
                    chk("lb_waddr", 32'(lb_waddr), 32'(el.col));
                    chk("lb_wdata", 32'(lb_wdata), 32'(el.data));
                end
            end

            e = (exp_done.size() > 0) && (exp_done[0] == cyc);
            if (e) void'(exp_done.pop_front());
            if (fetch_done || e) chk("fetch_done", 32'(fetch_done), 32'(e));

            e = (exp_err.size() > 0) && (exp_err[0] == cyc);
            if (e) void'(exp_err.pop_front());
            if (err || e) chk("err", 32'(err), 32'(e));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pick_wr(input int base, output logic [ADDR_W-1:0] wa, output logic [PIX_W-1:0] wd);
        int a;
        do a = int'($urandom_range(0, FB_W * FB_H - 1)); while (a >= base && a < base + FB_W);
        wa = ADDR_W'(a);
        wd = PIX_W'($urandom);
    endtask

    task automatic check_reset();
        wr_valid = 1'b1;
        @(negedge clk);
        chk("rst_fetch_busy", 32'(fetch_busy), 32'(0));
        chk("rst_fetch_done", 32'(fetch_done), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_lb_we", 32'(lb_we), 32'(0));
        chk("rst_wr_ready", 32'(wr_ready), 32'(0));
        chk("rst_ram_en", 32'(ram_en), 32'(0));
        wr_valid = 1'b0;
    endtask

    // Writer modes: 0 none, 1 always valid, 2 random, 3 raised at a non-slot cycle until granted.
    // A fetch issues one read per cycle except in each WR_EVERY-th fetch cycle that the writer
    // claims; the cycle after the last read is the drain cycle.
    task automatic run_fetch(input int row, input int mode, input int rej_mid,
                             input bit rej_drain, input int abort_at);
        int                base, reads;
        bit                drain, g, v, granted;
        logic [ADDR_W-1:0] wa;
        logic [PIX_W-1:0]  wd;
        lb_t               el;
        base = row * FB_W;
        for (int c = 0; c < FB_W; c++) begin
            exp_rd.push_back(base + c);
            el.col  = 8'(c);
            el.data = ref_mem[base + c];
            exp_lb.push_back(el);
        end
        bz_start = cyc + 1;
        bz_end   = 1 << 30;
        pick_wr(base, wa, wd);
        granted = 1'b0;
        reads   = 0;
        for (int i = 0; i <= 3 * FB_W + 4; i++) begin
            if (i == abort_at) begin
                nrst = 1'b0; fetch_req = 1'b0; wr_valid = 1'b0;
                exp_rd.delete(); exp_lb.delete(); exp_gnt.delete();
                exp_done.delete(); exp_err.delete();
                bz_start = 1; bz_end = 0;
                return;
            end
            drain     = (i > 0) && (reads == FB_W);
            fetch_req = (i == 0) || (i == rej_mid) || (drain && rej_drain);
            fetch_row = (i == 0) ? 7'(row) : 7'($urandom_range(0, FB_H - 1));
            if (i > 0 && fetch_req) exp_err.push_back(cyc + 1);
            case (mode)
                0:       v = 1'b0;
                1:       v = 1'b1;
                2:       v = 1'($urandom_range(0, 1));
                default: v = (i >= 3) && !granted;
            endcase
            wr_valid = v;
            wr_addr  = wa;
            wr_data  = wd;
            if (i == 0 || drain) begin
                g = v;
            end else if ((i % WR_EVERY) == 0 && v) begin
                g = 1'b1;
            end else begin
                g = 1'b0;
                reads++;
            end
            if (g) begin
                exp_gnt.push_back(cyc);
                ref_mem[wa] = wd;
                granted = 1'b1;
                pick_wr(base, wa, wd);
            end
            if (drain) begin
                exp_done.push_back(cyc);
                bz_end = cyc;
            end
            step();
            if (drain) break;
        end
        fetch_req = 1'b0;
        wr_valid  = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < MEM_N; a++) ref_mem[a] = PIX_W'($urandom);
        nrst = 1'b0; fetch_req = 1'b0; fetch_row = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        check_reset();
        step();
        nrst = 1'b1;
        step();

        // Plain fetch, then fetch with the writer always requesting
        run_fetch(2, 0, -1, 1'b0, -1);
        repeat (3) step();
        run_fetch(0, 1, -1, 1'b0, -1);
        repeat (3) step();

        // Idle write to the last pixel, then fetch the last row
        wr_valid = 1'b1;
        wr_addr  = ADDR_W'(FB_W * FB_H - 1);
        wr_data  = 12'hF00;
        exp_gnt.push_back(cyc);
        ref_mem[FB_W * FB_H - 1] = 12'hF00;
        @(negedge clk);
        chk("idle_wr_ready", 32'(wr_ready), 32'(1));
        chk("idle_ram_we", 32'(ram_we), 32'(1));
        chk("idle_ram_addr", 32'(ram_addr), 32'(FB_W * FB_H - 1));
        chk("idle_ram_wdata", 32'(ram_wdata), 32'h0F00);
        step();
        wr_valid = 1'b0;
        step();
        run_fetch(FB_H - 1, 0, -1, 1'b0, -1);
        repeat (2) step();

        // Requests during FETCH and DRAIN are rejected
        run_fetch(10, 0, 50, 1'b1, -1);
        repeat (2) step();

        // Out-of-range row in IDLE
        fetch_req = 1'b1;
        fetch_row = 7'(FB_H);
        exp_err.push_back(cyc + 1);
        step();
        fetch_req = 1'b0;
        step();
        @(negedge clk);
        chk("bad_row_stays_idle", 32'(wr_ready), 32'(1));
        step();

        // Writer raised outside its slot waits for the next slot
        run_fetch(7, 3, -1, 1'b0, -1);
        repeat (2) step();

        // Reset in the middle of a fetch, then a clean fetch
        run_fetch(30, 0, -1, 1'b0, 50);
        check_reset();
        step();
        nrst = 1'b1;
        step();
        run_fetch(30, 0, -1, 1'b0, -1);
        repeat (2) step();

        // Randomised fetches with random writer traffic and rejections
        for (int n = 0; n < 4; n++) begin
            run_fetch(int'($urandom_range(0, FB_H - 1)), 2,
                      int'($urandom_range(1, FB_W)), 1'($urandom_range(0, 1)), -1);
            repeat (int'($urandom_range(1, 4))) step();
        end

        repeat (3) step();
        chk("reads_left", 32'(exp_rd.size()), 32'(0));
        chk("lb_left", 32'(exp_lb.size()), 32'(0));
        chk("grants_left", 32'(exp_gnt.size()), 32'(0));
        chk("done_left", 32'(exp_done.size()), 32'(0));
        chk("err_left", 32'(exp_err.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_fb_fetch_arb.md
# vga_fb_fetch_arb

Shared-framebuffer arbiter and scanline fetch controller for the VGA path. It owns the single port of the pixel framebuffer RAM. On a fetch request for one framebuffer row, it streams that row into the display line buffer. While it does so, it shares the RAM with a pixel-writer port (drawing engine or CPU) through a valid/ready handshake. Display fetch has priority, and the writer is guaranteed one RAM slot every WR_EVERY fetch cycles so it cannot starve.

## Interface
Parameters:
- FB_W, 160: framebuffer width in pixels, 2..256.
- FB_H, 120: framebuffer height in rows, 1..128.
- PIX_W, 12: pixel width (4:4:4 RGB).
- ADDR_W, 15: RAM address width, must satisfy 2^ADDR_W >= FB_W*FB_H.
- WR_EVERY, 8: fetch-cycle period of the guaranteed writer slot, >= 2.

Ports:
- clk, in, 1: clock.
- nrst, in, 1: reset, asynchronous, active-low.
- fetch_req, in, 1: one-cycle pulse requesting a fetch of row fetch_row.
- fetch_row, in, 7: row index, sampled when fetch_req=1.
- fetch_busy, out, 1: high in the FETCH and DRAIN states.
- fetch_done, out, 1: one-cycle pulse in the cycle the last line-buffer write occurs.
- err, out, 1: one-cycle pulse when a fetch_req is rejected.
- lb_we, out, 1: line-buffer write enable.
- lb_waddr, out, 8: line-buffer column.
- lb_wdata, out, PIX_W: line-buffer data.
- ram_en, out, 1: RAM access enable.
- ram_we, out, 1: RAM write enable.
- ram_addr, out, ADDR_W: RAM address.
- ram_wdata, out, PIX_W: RAM write data.
- ram_rdata, in, PIX_W: RAM read data, valid one cycle after a read (ram_en=1, ram_we=0).
- wr_valid, in, 1: writer request.
- wr_ready, out, 1: writer grant.
- wr_addr, in, ADDR_W: writer pixel address.
- wr_data, in, PIX_W: writer pixel data.

## Operation
- The FSM has three states: IDLE, FETCH and DRAIN. Internal registers are the column counter col (0..FB_W-1), the slot counter slot (0..WR_EVERY-1) and the base address base = row*FB_W.
- IDLE:
  - wr_ready=1.
  - If fetch_req=1 and fetch_row < FB_H: latch base, clear col and slot, and go to FETCH.
  - If fetch_row >= FB_H: pulse err and stay in IDLE.
- FETCH, each cycle:
  - Writer slot: when slot==WR_EVERY-1 and wr_valid=1, the writer owns the RAM this cycle. wr_ready=1, no read is issued and col holds.
  - Otherwise, issue a read: ram_en=1, ram_we=0, ram_addr=base+col. Then col increments.
  - slot increments every FETCH cycle, modulo WR_EVERY.
  - After the read with col==FB_W-1 is issued, go to DRAIN.
- DRAIN:
  - Lasts one cycle, with wr_ready=1.
  - The last line-buffer write and the fetch_done pulse occur here. Then go to IDLE.
- Line-buffer write: one cycle after each issued read, assert lb_we=1 with lb_waddr = the col of that read and lb_wdata = ram_rdata.
- Writer port:
  - A write occurs when wr_valid=1 and wr_ready=1: ram_en=1, ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data.
  - wr_ready is 0 in FETCH except in the writer-slot cycle.
  - wr_ready does not depend on wr_valid.
- Rejections:
  - fetch_req while fetch_busy=1, including during DRAIN, is ignored and pulses err.
  - The fetch in progress is unaffected.
- Combinational versus registered outputs:
  - ram_*, lb_* and wr_ready are combinational from state and registers.
  - lb_* is a registered copy of the previous cycle's read.
  - fetch_busy, fetch_done and err are registered.
- Address arithmetic:
  - base is computed as fetch_row*FB_W truncated to ADDR_W.
  - base+col never exceeds FB_W*FB_H-1.
- A fetch_req in the same IDLE cycle as a writer request: the writer is granted that cycle and FETCH starts next cycle.

## Timing
- Reset values, while nrst is low and after reset:
  - state=IDLE; col, slot, fetch_busy, fetch_done, err and lb_we all 0.
  - wr_ready is forced to 0 while nrst=0, so ram_en=0.
- Reset mid-fetch aborts immediately. There is no fetch_done and no further lb_we.
- fetch_req sampled at cycle 0 gives fetch_busy=1 from cycle 1. Reads are issued from cycle 1.
- With no writer activity:
  - Reads occur in cycles 1..FB_W and DRAIN is cycle FB_W+1.
  - fetch_done pulses in cycle FB_W+1 and fetch_busy=0 in cycle FB_W+2.
- With the writer always valid:
  - Fetch takes FB_W + floor((FB_W-1)/(WR_EVERY-1)) cycles.
  - The writer receives one grant in each of those slots.
- Writer latency in IDLE or DRAIN: zero cycles, since the write is accepted in the cycle wr_valid is seen.

## Test plan
- Fetch with no writer: reset, then fetch_row=2 with no writer.
  - Reads to addresses 320..479 occur in cycles 1..160.
  - lb_waddr runs 0..159 with the data matching, and fetch_done pulses at cycle 161.
- Fetch with the writer always valid: fetch_row=0 with wr_valid held at 1 (FB_W=160, WR_EVERY=8).
  - Writer grants occur at FETCH cycles 8, 16, …, 176, 22 in total.
  - The last read is at cycle 182 and fetch_done pulses at cycle 183.
  - Line-buffer contents are unchanged versus the no-writer case.
- Idle write: wr_valid=1, wr_addr=19199, wr_data=0xF00 in IDLE.
  - wr_ready=1, ram_we=1 and ram_addr=19199 in the same cycle.
  - A later fetch of row 119 returns 0xF00 at column 159.
- Rejected requests:
  - fetch_req during FETCH, and fetch_req during DRAIN, each give a single err pulse with no restart and unchanged fetch_done timing.
  - fetch_row=120 in IDLE gives err=1 and the state stays IDLE.
- Reset mid-fetch: nrst low at fetch cycle 50.
  - All outputs return to reset values, with no fetch_done.
  - A subsequent fetch completes normally.
- Writer slot with no writer: wr_valid raised only in non-slot FETCH cycles.
  - wr_ready=0 in those cycles, with no write.
  - The write is granted at the next slot cycle.
